// File: rtl/hdp_receiver.sv
// hdp_receiver: sink-side decoder for the HDP LCD packet stream.
// Tracks packet/line/frame position, tags each valid packet and keeps sticky framing errors.
module hdp_receiver #(
  parameter int PACKETS_PER_LINE = 40,
  parameter int BLANK_PER_LINE   = 4,
  parameter int LINES            = 1280,
  parameter int BACK_PORCH       = 24,
  parameter int UPDATE_LEN       = 28
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_lcdData,
  input  logic        i_valid,
  input  logic        i_update,
  input  logic        i_nReset,
  output logic [31:0] o_wordData,
  output logic        o_wordValid,
  output logic [5:0]  o_column,
  output logic [10:0] o_line,
  output logic        o_lineDone,
  output logic        o_frameDone,
  output logic [15:0] o_frameCount,
  output logic [3:0]  o_errFlags,
  output logic        o_locked
);
  localparam int FRAME_LEN = (PACKETS_PER_LINE + BLANK_PER_LINE) * LINES + BACK_PORCH;
  localparam logic [7:0]  LAST_COL   = 8'(PACKETS_PER_LINE - 1);
  localparam logic [7:0]  LAST_POS   = 8'(PACKETS_PER_LINE + BLANK_PER_LINE - 1);
  localparam logic [7:0]  LAST_PORCH = 8'(BACK_PORCH - 1);
  localparam logic [10:0] LAST_LINE  = 11'(LINES - 1);
  localparam logic [16:0] LAST_FC    = 17'(FRAME_LEN - 1);
  localparam logic [16:0] UPD_END    = 17'(UPDATE_LEN);

  typedef enum logic [2:0] {s_WAIT_RESET, s_HUNT, s_ACTIVE, s_BLANK, s_PORCH} state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_pos, w_pos;   // in-line position (active + blank) or porch cycle
  logic [10:0] r_line, w_line;
  logic [16:0] r_fc, w_fc;
  logic        r_prev_update, r_prev_nreset;
  logic        w_start, w_emit, w_line_done, w_frame_done;
  logic [5:0]  w_out_col;
  logic [10:0] w_out_line;
  logic [3:0]  w_err;

  logic [31:0] r_word_data;
  logic        r_word_valid, r_line_done, r_frame_done, r_locked;
  logic [5:0]  r_column;
  logic [10:0] r_out_line;
  logic [15:0] r_frame_count;
  logic [3:0]  r_err_flags;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    w_next       = r_state;
    w_pos        = r_pos;
    w_line       = r_line;
    w_fc         = r_fc;
    w_emit       = 1'b0;
    w_line_done  = 1'b0;
    w_frame_done = 1'b0;
    w_out_col    = 6'd0;
    w_out_line   = 11'd0;
    w_err        = 4'b0000;
    w_start      = i_update && i_valid && (!r_prev_update || !r_prev_nreset);

    if (r_state == s_ACTIVE || r_state == s_BLANK || r_state == s_PORCH) begin
      if (i_update != (r_fc < UPD_END)) w_err[3] = 1'b1;
      w_fc = (r_fc == LAST_FC) ? 17'd0 : r_fc + 17'd1;
    end

    case (r_state)
      s_WAIT_RESET: w_next = s_HUNT;
      s_HUNT: begin
        if (w_start) begin
          w_emit = 1'b1;
          w_pos  = 8'd1;
          w_line = 11'd0;
          w_fc   = 17'd1;
          w_next = (LAST_COL == 8'd0) ? s_BLANK : s_ACTIVE;
        end
      end
      s_ACTIVE: begin
        // Column 0 of line 0 here only follows a porch: it must be a fresh frame start.
        if (r_pos == 8'd0 && r_line == 11'd0 && !w_start) begin
          w_err[3] = 1'b1;
          w_next   = s_HUNT;
        end else if (!i_valid) begin
          w_err[0] = 1'b1;
          w_next   = s_HUNT;
        end else begin
          w_emit     = 1'b1;
          w_out_col  = r_pos[5:0];
          w_out_line = r_line;
          w_pos      = r_pos + 8'd1;
          if (r_pos == LAST_COL) w_next = s_BLANK;
        end
      end
      s_BLANK: begin
        if (i_valid) w_err[1] = 1'b1;
        if (i_lcdData != 32'd0) w_err[2] = 1'b1;
        if (r_pos == LAST_POS) begin
          w_line_done = 1'b1;
          w_pos       = 8'd0;
          if (r_line == LAST_LINE) begin
            w_next = s_PORCH;
          end else begin
            w_line = r_line + 11'd1;
            w_next = s_ACTIVE;
          end
        end else begin
          w_pos = r_pos + 8'd1;
        end
      end
      s_PORCH: begin
        if (i_valid) w_err[1] = 1'b1;
        if (r_pos == LAST_PORCH) begin
          w_frame_done = 1'b1;
          w_pos        = 8'd0;
          w_line       = 11'd0;
          w_next       = s_ACTIVE;
        end else begin
          w_pos = r_pos + 8'd1;
        end
      end
      default: w_next = s_WAIT_RESET;
    endcase

    if (!i_nReset) begin
      w_next       = s_WAIT_RESET;
      w_pos        = 8'd0;
      w_line       = 11'd0;
      w_fc         = 17'd0;
      w_emit       = 1'b0;
      w_line_done  = 1'b0;
      w_frame_done = 1'b0;
      w_err        = 4'b0000;
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (i_reset) begin
      r_state       <= s_WAIT_RESET;
      r_pos         <= 8'd0;
      r_line        <= 11'd0;
      r_fc          <= 17'd0;
      r_prev_update <= 1'b0;
      r_prev_nreset <= 1'b0;
      r_word_data   <= 32'd0;
      r_word_valid  <= 1'b0;
      r_column      <= 6'd0;
      r_out_line    <= 11'd0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_err_flags   <= 4'b0000;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pos         <= w_pos;
      r_line        <= w_line;
      r_fc          <= w_fc;
      r_prev_update <= i_update;
      r_prev_nreset <= i_nReset;
      r_word_valid  <= w_emit;
      if (w_emit) begin
        r_word_data <= i_lcdData;
        r_column    <= w_out_col;
        r_out_line  <= w_out_line;
      end else if (!i_nReset) begin
        r_column   <= 6'd0;
        r_out_line <= 11'd0;
      end
      r_line_done  <= w_line_done;
      r_frame_done <= w_frame_done;
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
      r_err_flags  <= r_err_flags | w_err;
      r_locked     <= (w_next == s_ACTIVE) || (w_next == s_BLANK) || (w_next == s_PORCH);
    end
  end

  assign o_wordData   = r_word_data;
  assign o_wordValid  = r_word_valid;
  assign o_column     = r_column;
  assign o_line       = r_out_line;
  assign o_lineDone   = r_line_done;
  assign o_frameDone  = r_frame_done;
  assign o_frameCount = r_frame_count;
  assign o_errFlags   = r_err_flags;
  assign o_locked     = r_locked;
endmodule

// File: tb/tb_hdp_receiver.sv
// tb_hdp_receiver: directed scenarios plus randomized frames for hdp_receiver, checked every
// cycle against a frame-position reference model (frame cycle -> line/column by division).
module tb_hdp_receiver;
  localparam int PPL   = 4;
  localparam int BPL   = 2;
  localparam int LINES = 3;
  localparam int BP    = 5;
  localparam int UPD   = 3;
  localparam int LL    = PPL + BPL;
  localparam int F     = LL * LINES + BP;

  localparam int K_CLEAN = 0, K_DROP = 1, K_BLANK = 2, K_UPD = 3, K_NRES = 4, K_RST = 5, K_RAND = 6;
  localparam int M_WAIT = 0, M_HUNT = 1, M_LOCK = 2;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_valid = 1'b0, i_update = 1'b0, i_nReset = 1'b1;
  logic [31:0] i_lcdData = 32'd0;
  logic [31:0] o_wordData;
  logic        o_wordValid, o_lineDone, o_frameDone, o_locked;
  logic [5:0]  o_column;
  logic [10:0] o_line;
  logic [15:0] o_frameCount;
  logic [3:0]  o_errFlags;

  hdp_receiver #(.PACKETS_PER_LINE(PPL), .BLANK_PER_LINE(BPL), .LINES(LINES),
                 .BACK_PORCH(BP), .UPDATE_LEN(UPD)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_lcdData(i_lcdData), .i_valid(i_valid),
    .i_update(i_update), .i_nReset(i_nReset), .o_wordData(o_wordData),
    .o_wordValid(o_wordValid), .o_column(o_column), .o_line(o_line),
    .o_lineDone(o_lineDone), .o_frameDone(o_frameDone), .o_frameCount(o_frameCount),
    .o_errFlags(o_errFlags), .o_locked(o_locked));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int n_words = 0, n_ld = 0, n_fd = 0;

  // reference model state and expected outputs
  int          m_mode, m_fc;
  logic        m_prev_upd, m_prev_nres;
  logic [3:0]  m_err;
  logic [15:0] m_frames;
  logic [31:0] e_data;
  logic [5:0]  e_col;
  logic [10:0] e_line;
  logic        e_wv, e_ld, e_fd, e_locked;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_emit(input logic [31:0] data, input int col, input int ln);
    e_wv   = 1'b1;
    e_data = data;
    e_col  = 6'(col);
    e_line = 11'(ln);
  endtask

  task automatic model_step(input logic rst, input logic [31:0] data, input logic val,
                            input logic upd, input logic nres);
    int   pos, ln;
    logic start;
    e_wv = 1'b0; e_ld = 1'b0; e_fd = 1'b0;
    start = upd && val && (!m_prev_upd || !m_prev_nres);
    if (rst) begin
      m_mode = M_WAIT; m_fc = 0; m_err = 4'b0; m_frames = 16'd0;
      e_data = 32'd0; e_col = 6'd0; e_line = 11'd0;
      m_prev_upd = 1'b0; m_prev_nres = 1'b0;
    end else begin
      if (!nres) begin
        m_mode = M_WAIT; e_col = 6'd0; e_line = 11'd0;
      end else if (m_mode == M_WAIT) begin
        m_mode = M_HUNT;
      end else if (m_mode == M_HUNT) begin
        if (start) begin
          model_emit(data, 0, 0);
          m_mode = M_LOCK;
          m_fc   = 1;
        end
      end else begin
        if (upd != (m_fc < UPD)) m_err[3] = 1'b1;
        pos = m_fc % LL;
        ln  = m_fc / LL;
        if (m_fc == 0) begin
          if (!start) begin m_err[3] = 1'b1; m_mode = M_HUNT; end
          else model_emit(data, 0, 0);
        end else if (ln < LINES && pos < PPL) begin
          if (val) model_emit(data, pos, ln);
          else begin m_err[0] = 1'b1; m_mode = M_HUNT; end
        end else if (ln < LINES) begin
          if (val) m_err[1] = 1'b1;
          if (data != 32'd0) m_err[2] = 1'b1;
          if (pos == LL - 1) e_ld = 1'b1;
        end else begin
          if (val) m_err[1] = 1'b1;
          if (m_fc == F - 1) begin e_fd = 1'b1; m_frames = m_frames + 16'd1; end
        end
        m_fc = (m_fc == F - 1) ? 0 : m_fc + 1;
      end
      m_prev_upd  = upd;
      m_prev_nres = nres;
    end
    e_locked = (m_mode == M_LOCK);
  endtask

  task automatic step(input logic rst, input logic [31:0] data, input logic val,
                      input logic upd, input logic nres);
    @(negedge clk);
    i_reset = rst; i_lcdData = data; i_valid = val; i_update = upd; i_nReset = nres;
    model_step(rst, data, val, upd, nres);
    @(posedge clk);
    #1;
    check("wordValid",  32'(o_wordValid),  32'(e_wv));
    check("wordData",   o_wordData,        e_data);
    check("column",     32'(o_column),     32'(e_col));
    check("line",       32'(o_line),       32'(e_line));
    check("lineDone",   32'(o_lineDone),   32'(e_ld));
    check("frameDone",  32'(o_frameDone),  32'(e_fd));
    check("frameCount", 32'(o_frameCount), 32'(m_frames));
    check("errFlags",   32'(o_errFlags),   32'(m_err));
    check("locked",     32'(o_locked),     32'(e_locked));
    if (o_wordValid) n_words++;
    if (o_lineDone)  n_ld++;
    if (o_frameDone) n_fd++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic restart();
    step(1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(2);
    n_words = 0; n_ld = 0; n_fd = 0;
  endtask

  // Drives frame cycles first..last of one frame, with an optional planted fault.
  task automatic send_range(input int kind, input int first, input int last);
    int          pos, ln;
    logic        in_act, val, upd, nres, rst;
    logic [31:0] data;
    for (int fc = first; fc <= last; fc++) begin
      pos    = fc % LL;
      ln     = fc / LL;
      in_act = (ln < LINES) && (pos < PPL);
      val    = in_act;
      upd    = (fc < UPD);
      nres   = 1'b1;
      rst    = 1'b0;
      data   = in_act ? $urandom : 32'd0;
      case (kind)
        K_DROP:  if (fc == LL + 2) val = 1'b0;
        K_BLANK: begin
          if (fc == PPL)   data = 32'h1;
          if (fc == F - 2) val  = 1'b1;
        end
        K_UPD:   upd = (fc < UPD + 1);
        K_NRES:  if (fc >= LL + 1 && fc <= LL + 3) nres = 1'b0;
        K_RST:   if (fc == LL) rst = 1'b1;
        K_RAND: begin
          if ($urandom_range(0, 29) == 0) val = !val;
          if ($urandom_range(0, 29) == 0) upd = !upd;
          if (!in_act && $urandom_range(0, 19) == 0) data = $urandom;
          if ($urandom_range(0, 79) == 0) nres = 1'b0;
          if ($urandom_range(0, 299) == 0) rst = 1'b1;
        end
        default: ;
      endcase
      step(rst, data, val, upd, nres);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    restart();

    // two clean back-to-back frames
    send_range(K_CLEAN, 0, F - 1);
    send_range(K_CLEAN, 0, F - 1);
    check("clean_words", 32'(n_words), 32'd24);
    check("clean_lineDone", 32'(n_ld), 32'd6);
    check("clean_frameDone", 32'(n_fd), 32'd2);
    check("clean_count", 32'(o_frameCount), 32'd2);
    check("clean_err", 32'(o_errFlags), 32'd0);

    // dropped valid at line 1 column 2, then relock
    send_range(K_DROP, 0, LL + 2);
    check("drop_err", 32'(o_errFlags), 32'h1);
    check("drop_locked", 32'(o_locked), 32'd0);
    send_range(K_DROP, LL + 3, F - 1);
    check("drop_count", 32'(o_frameCount), 32'd2);
    send_range(K_CLEAN, 0, 0);
    check("relock_locked", 32'(o_locked), 32'd1);
    send_range(K_CLEAN, 1, F - 1);
    check("relock_count", 32'(o_frameCount), 32'd3);

    // nonzero blank data and valid in porch: flagged but tracking continues
    restart();
    send_range(K_BLANK, 0, F - 1);
    check("blank_err", 32'(o_errFlags), 32'h6);
    check("blank_frameDone", 32'(o_frameDone), 32'd1);
    check("blank_words", 32'(n_words), 32'd12);

    // update held one cycle too long
    restart();
    send_range(K_UPD, 0, F - 1);
    check("upd_err", 32'(o_errFlags), 32'h8);
    check("upd_words", 32'(n_words), 32'd12);

    // panel reset pulse mid-frame
    restart();
    send_range(K_CLEAN, 0, F - 1);
    send_range(K_NRES, 0, LL + 1);
    check("nres_locked", 32'(o_locked), 32'd0);
    check("nres_wv", 32'(o_wordValid), 32'd0);
    send_range(K_NRES, LL + 2, F - 1);
    send_range(K_CLEAN, 0, 0);
    check("nres_relock_col", 32'(o_column), 32'd0);
    check("nres_relock_line", 32'(o_line), 32'd0);
    check("nres_relock_wv", 32'(o_wordValid), 32'd1);
    check("nres_count", 32'(o_frameCount), 32'd1);
    send_range(K_CLEAN, 1, F - 1);

    // synchronous reset mid-frame with valid high
    restart();
    send_range(K_UPD, 0, F - 1);
    send_range(K_RST, 0, LL);
    check("rst_err", 32'(o_errFlags), 32'd0);
    check("rst_count", 32'(o_frameCount), 32'd0);
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_data", o_wordData, 32'd0);
    send_range(K_CLEAN, LL + 1, F - 1);

    // randomized frames with random gaps and faults
    restart();
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send_range(($urandom_range(0, 2) == 0) ? K_RAND : K_CLEAN, 0, F - 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
